// File: rtl/eth_tx_framer.sv
// GMII transmit framer: pulls bytes from the TX FIFO stream, adds preamble/SFD,
// pads short frames, enforces the inter-frame gap and aborts cleanly on underrun.
module eth_tx_framer #(
  parameter int AXI_DATA_WIDTH  = 8,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int PREAMBLE_BYTES  = 7,
  parameter int IFG_BYTES       = 12
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_trdy,
  output logic [7:0]                gmii_txd,
  output logic                      gmii_tx_en,
  output logic                      gmii_tx_er,
  output logic                      tx_busy,
  output logic                      frame_done,
  output logic                      underrun
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, DROP, IFG
  } state_e;

  localparam logic [15:0] MIN_C = 16'(MIN_FRAME_BYTES);
  localparam logic [7:0]  PRE_L = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  IFG_L = 8'(IFG_BYTES - 1);

  state_e      state_q, state_d;
  logic [7:0]  pcnt_q, pcnt_d;    // preamble / IFG cycle counter
  logic [15:0] cnt_q, cnt_d;      // bytes sent after SFD (data + pad)
  logic [7:0]  hold_q, hold_d;    // byte accepted last edge, driven this edge
  logic        tail_q, tail_d;    // last byte accepted, still to be driven
  logic        first_q, first_d;  // first DROP cycle carries the error symbol
  logic        ok_q, ok_d;        // current IFG follows a good frame

  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d, er_q, er_d, trdy_q, trdy_d;
  logic        busy_q, busy_d, done_q, done_d, urun_q, urun_d;
  logic [15:0] cnt_inc;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    tail_d  = tail_q;
    first_d = first_q;
    ok_d    = ok_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    done_d  = 1'b0;
    urun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          state_d = PREAMBLE;
          pcnt_d  = 8'd0;
          cnt_d   = 16'd0;
        end
      end
      PREAMBLE: begin
        txd_d = 8'h55;
        en_d  = 1'b1;
        if (pcnt_q == PRE_L) state_d = SFD;
        else                 pcnt_d  = pcnt_q + 8'd1;
      end
      SFD, DATA: begin
        // Output is one byte behind acceptance: SFD goes out while byte 0 is taken.
        en_d  = 1'b1;
        txd_d = (state_q == SFD) ? 8'hD5 : hold_q;
        if (state_q == DATA && tail_q) begin
          tail_d = 1'b0;
          if (cnt_q >= MIN_C) begin
            state_d = IFG;
            pcnt_d  = 8'd0;
            ok_d    = 1'b1;
          end else begin
            state_d = PAD;
          end
        end else if (s_axis_tvalid) begin
          hold_d  = s_axis_tdata[7:0];
          cnt_d   = cnt_inc;
          state_d = DATA;
          tail_d  = s_axis_tlast;
        end else begin
          state_d = DROP;
          first_d = 1'b1;
        end
      end
      PAD: begin
        en_d  = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_inc >= MIN_C) begin
          state_d = IFG;
          pcnt_d  = 8'd0;
          ok_d    = 1'b1;
        end
      end
      DROP: begin
        first_d = 1'b0;
        if (first_q) begin
          en_d   = 1'b1;
          er_d   = 1'b1;
          urun_d = 1'b1;
        end
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = IFG;
          pcnt_d  = 8'd0;
          ok_d    = 1'b0;
        end
      end
      IFG: begin
        done_d = (pcnt_q == 8'd0) && ok_q;
        if (pcnt_q == IFG_L) begin
          if (s_axis_tvalid) begin
            state_d = PREAMBLE;
            pcnt_d  = 8'd0;
            cnt_d   = 16'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    trdy_d = (state_d == SFD) || (state_d == DATA && !tail_d) || (state_d == DROP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      tail_q  <= 1'b0;
      first_q <= 1'b0;
      ok_q    <= 1'b0;
      txd_q   <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      trdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      tail_q  <= tail_d;
      first_q <= first_d;
      ok_q    <= ok_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
      trdy_q  <= trdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign s_axis_trdy = trdy_q;
  assign gmii_txd    = txd_q;
  assign gmii_tx_en  = en_q;
  assign gmii_tx_er  = er_q;
  assign tx_busy     = busy_q;
  assign frame_done  = done_q;
  assign underrun    = urun_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: FIFO-like byte source, per-cycle bus trace, and
// frame-level checks against bench-built expected GMII byte streams.
module tb_eth_tx_framer;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tlast, s_axis_trdy;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun;

  eth_tx_framer dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_trdy(s_axis_trdy),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .tx_busy(tx_busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #4 aclk = ~aclk;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         gap;   // idle cycles presented before this byte
  } ent_t;

  typedef struct packed {
    logic       en, er, done, urun, trdy, tv;
    logic [7:0] txd;
  } smp_t;

  typedef struct {
    int len;
    int start;
    int exp_en;
  } vec_t;

  ent_t       src[$];
  smp_t       trace[$];
  logic [7:0] got[$], expq[$];
  int         checks = 0, errors = 0, en_seen = 0;
  int         n_en, n_er, n_done, n_urun, first_tv, first_en, first_trdy, er_pos, n_gaps, last_gap;

  // Source + monitor: at each falling edge record the bus, then advance the FIFO model.
  initial begin
    bit fire = 0;
    s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0;
    forever begin
      @(negedge aclk);
      trace.push_back('{en: gmii_tx_en, er: gmii_tx_er, done: frame_done, urun: underrun,
                        trdy: s_axis_trdy, tv: s_axis_tvalid, txd: gmii_txd});
      if (gmii_tx_en) en_seen++;
      if (!aresetn) begin
        src.delete(); fire = 0;
        s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0;
      end else begin
        if (fire && src.size() > 0) void'(src.pop_front());
        if (src.size() > 0 && src[0].gap > 0) begin
          src[0].gap = src[0].gap - 1;
          s_axis_tvalid = 0;
        end else if (src.size() > 0) begin
          s_axis_tvalid = 1; s_axis_tdata = src[0].d; s_axis_tlast = src[0].last;
        end else begin
          s_axis_tvalid = 0;
        end
        fire = s_axis_tvalid && s_axis_trdy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int len, input int start, input int gap_at, input int gap_len);
    ent_t e;
    for (int i = 0; i < len; i++) begin
      e.d = 8'(start + i); e.last = (i == len - 1); e.gap = (i == gap_at) ? gap_len : 0;
      src.push_back(e);
    end
  endtask

  // Expected bus bytes for a good frame: preamble, SFD, payload, zero pad to 60.
  task automatic exp_frame(input int len, input int start);
    for (int i = 0; i < 7; i++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    for (int i = 0; i < len; i++) expq.push_back(8'(start + i));
    for (int i = len; i < 60; i++) expq.push_back(8'h00);
  endtask

  task automatic wait_idle(input string name);
    bit seen = 0, ok = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge aclk);
      if (tx_busy) seen = 1;
      if (seen && !tx_busy && src.size() == 0) begin ok = 1; break; end
    end
    repeat (3) @(negedge aclk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0d expected idle within 4000 cycles", name, tx_busy);
    end
  endtask

  task automatic analyze();
    int run = 0;
    got.delete();
    n_en = 0; n_er = 0; n_done = 0; n_urun = 0; first_tv = -1; first_en = -1;
    first_trdy = -1; er_pos = -1; n_gaps = 0; last_gap = 0;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i].tv && first_tv < 0) first_tv = i;
      if (trace[i].trdy && first_trdy < 0) first_trdy = i;
      if (trace[i].er) begin n_er++; er_pos = got.size(); end
      if (trace[i].done) n_done++;
      if (trace[i].urun) n_urun++;
      if (trace[i].en) begin
        if (first_en < 0) first_en = i;
        if (run > 0) begin n_gaps++; last_gap = run; end
        run = 0; n_en++;
        got.push_back(trace[i].txd);
      end else if (first_en >= 0) begin
        run++;
      end
    end
  endtask

  task automatic cmp_bytes(input string name);
    int mism = 0;
    chk({name, "_len"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) mism++;
    chk({name, "_byte_mismatches"}, mism, 0);
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{64, 'h00, 72};  // full-size frame, no pad
    vt[1] = '{10, 'hA0, 68};  // padded with 50 zeros
    vt[2] = '{60, 'h20, 68};  // exactly minimum
    vt[3] = '{1,  'h7E, 68};  // tlast on the very first byte
    vt[4] = '{59, 'h40, 68};  // one pad byte
    vt[5] = '{61, 'h90, 69};  // one over minimum

    aresetn = 0;
    #1;
    chk("reset_outputs", int'({gmii_txd, gmii_tx_en, gmii_tx_er, s_axis_trdy, tx_busy, frame_done, underrun}), 0);
    repeat (3) @(negedge aclk);
    #2 aresetn = 1;
    @(negedge aclk);

    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("frame%0d_len%0d", v, vt[v].len);
      trace.delete(); expq.delete();
      exp_frame(vt[v].len, vt[v].start);
      push_frame(vt[v].len, vt[v].start, -1, 0);
      wait_idle(nm);
      analyze();
      cmp_bytes(nm);
      chk({nm, "_tx_en_cycles"}, n_en, vt[v].exp_en);
      chk({nm, "_frame_done"}, n_done, 1);
      chk({nm, "_tx_er"}, n_er, 0);
      chk({nm, "_underrun"}, n_urun, 0);
      chk({nm, "_first_en_latency"}, first_en - first_tv, 1);
      chk({nm, "_first_trdy_latency"}, first_trdy - first_tv, 7);
    end

    // Two back-to-back minimum frames with the stream never running dry.
    trace.delete(); expq.delete();
    exp_frame(60, 'h10); exp_frame(60, 'h80);
    push_frame(60, 'h10, -1, 0); push_frame(60, 'h80, -1, 0);
    wait_idle("b2b");
    analyze();
    cmp_bytes("b2b");
    chk("b2b_tx_en_cycles", n_en, 136);
    chk("b2b_gaps", n_gaps, 1);
    chk("b2b_gap_len", last_gap, 12);
    chk("b2b_frame_done", n_done, 2);

    // Underrun: 3 idle cycles before byte 10 of 30, then a good 20-byte frame.
    // Gap = 1 stalled cycle after the error + 20 dropped bytes + 12 IFG = 33.
    trace.delete(); expq.delete();
    for (int i = 0; i < 7; i++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    for (int i = 0; i < 10; i++) expq.push_back(8'('h30 + i));
    expq.push_back(8'h00);
    exp_frame(20, 'hC0);
    push_frame(30, 'h30, 10, 3); push_frame(20, 'hC0, -1, 0);
    wait_idle("urun");
    analyze();
    cmp_bytes("urun");
    chk("urun_tx_er_cycles", n_er, 1);
    chk("urun_tx_er_position", er_pos, 18);
    chk("urun_pulses", n_urun, 1);
    chk("urun_frame_done", n_done, 1);
    chk("urun_gap_len", last_gap, 33);

    // Reset in the middle of a 100-byte frame, then a clean 60-byte frame.
    trace.delete(); en_seen = 0;
    push_frame(100, 'h00, -1, 0);
    begin
      bit hit = 0;
      for (int k = 0; k < 500; k++) begin
        @(negedge aclk);
        if (en_seen >= 28) begin hit = 1; break; end
      end
      chk("rst_mid_reached_byte20", int'(hit), 1);
    end
    chk("rst_mid_en_before", int'(gmii_tx_en), 1);
    #2 aresetn = 0;
    #1;
    chk("rst_mid_outputs", int'({gmii_txd, gmii_tx_en, gmii_tx_er, s_axis_trdy, tx_busy, frame_done, underrun}), 0);
    repeat (3) @(negedge aclk);
    #2 aresetn = 1;
    @(negedge aclk);
    trace.delete(); expq.delete();
    exp_frame(60, 'h55);
    push_frame(60, 'h55, -1, 0);
    wait_idle("post_rst");
    analyze();
    cmp_bytes("post_rst");
    chk("post_rst_tx_en_cycles", n_en, 68);
    chk("post_rst_frame_done", n_done, 1);
    chk("post_rst_tx_er", n_er, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
